// File: rtl/gpio_seg_pkg.sv
// gpio_seg_pkg: shared types and constants for the 7-segment scanner
package gpio_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } seg_state_e;

    function automatic logic [NUM_DIGITS-1:0] an_inactive(input bit active_low);
        return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/gpio_seg_scan.sv
// gpio_seg_scan: time-multiplexes eight snapshotted 7-segment patterns onto one bus
module gpio_seg_scan
    import gpio_seg_pkg::*;
#(
    parameter int unsigned DIV_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_INVERT    = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SEG_W-1:0]      seg_in_0,
    input  logic [SEG_W-1:0]      seg_in_1,
    input  logic [SEG_W-1:0]      seg_in_2,
    input  logic [SEG_W-1:0]      seg_in_3,
    input  logic [SEG_W-1:0]      seg_in_4,
    input  logic [SEG_W-1:0]      seg_in_5,
    input  logic [SEG_W-1:0]      seg_in_6,
    input  logic [SEG_W-1:0]      seg_in_7,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic                  frame_start,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int unsigned MAX_C = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] DIV_C = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] BLK_C = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    // Each digit is entered through BLANK unless blanking is disabled.
    localparam seg_state_e ENTRY_S = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    localparam logic [CW-1:0] ENTRY_C = (BLANK_CYCLES == 0) ? DIV_C : BLK_C;
    // Inversion is an XOR with the off level, so 8'h00 maps to the off level either way.
    localparam logic [SEG_W-1:0] SEG_OFF = SEG_INVERT ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = an_inactive(AN_ACTIVE_LOW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    seg_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SEG_W-1:0]        snap_q [NUM_DIGITS];
    logic [SEG_W-1:0]        snap_d [NUM_DIGITS];
    logic [SEG_W-1:0]        live   [NUM_DIGITS];
    logic [SEG_W-1:0]        seg_out_d;
    logic [NUM_DIGITS-1:0]   seg_an_d;
    logic                    frame_start_d;
    logic                    start;

    assign live = '{seg_in_0, seg_in_1, seg_in_2, seg_in_3,
                    seg_in_4, seg_in_5, seg_in_6, seg_in_7};
    assign digit_idx = idx_q;

    // Next-state timer/FSM; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        start         = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: start = 1'b1;
                BLANK: begin
                    state_d = (cnt_q == ONE_C) ? SHOW : BLANK;
                    cnt_d   = (cnt_q == ONE_C) ? DIV_C : cnt_q - ONE_C;
                end
                SHOW: begin
                    if (cnt_q != ONE_C) begin
                        cnt_d = cnt_q - ONE_C;
                    end else if (idx_q == LAST_IDX) begin
                        start = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ENTRY_S;
                        cnt_d   = ENTRY_C;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start) begin
                state_d       = ENTRY_S;
                cnt_d         = ENTRY_C;
                idx_d         = '0;
                snap_d        = live;
                frame_start_d = 1'b1;
            end
        end
        seg_an_d  = (state_d == SHOW) ? AN_OFF ^ (NUM_DIGITS'(1) << idx_d) : AN_OFF;
        seg_out_d = (state_d == SHOW) ? snap_d[idx_d] ^ SEG_OFF : SEG_OFF;
    end

    // State, snapshot and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '{default: '0};
            seg_an      <= AN_OFF;
            seg_out     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            seg_an      <= seg_an_d;
            seg_out     <= seg_out_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: doc/gpio_seg_scan.md
Name: gpio_seg_scan

Overview:
- Downstream consumer of the GPIO peripheral's eight 7-segment pattern buses (digits 0..7, 8 bits each).
- Time-multiplexes the eight patterns onto one shared segment bus plus eight digit-enable (anode) lines for the board display.
- Snapshots all eight patterns once per frame so a software update mid-frame never tears.
- Inserts programmable blanking between digits to suppress ghosting.

Parameters:
- DIV_CYCLES, 1000: clock cycles each digit is shown; legal range 1 and up.
- BLANK_CYCLES, 16: all-off clock cycles before each digit is shown; 0 is legal and means no blanking.
- AN_ACTIVE_LOW, 1: 1 = digit enable asserted low; 0 = asserted high.
- SEG_INVERT, 0: 1 = seg_out is the bitwise inverse of the pattern; 0 = pass-through.

Ports:
- clock, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: scanning runs while high.
- seg_in_0 .. seg_in_7, input, 8 each: raw digit patterns from the GPIO block; bit 7 is the decimal point.
- seg_out, output, 8: shared segment bus.
- seg_an, output, 8: digit enables; bit d selects digit d.
- frame_start, output, 1: one-cycle pulse in the cycle a new snapshot becomes active.
- digit_idx, output, 3: index of the current digit, for debug.

Behaviour:
- Every output is a register. No output is a combinational decode.
- Digit enable levels:
  - Inactive level: all-ones when AN_ACTIVE_LOW=1, all-zeros otherwise.
  - Active enable for digit d: only bit d at the active level.
- Segment "off" level:
  - 8'h00 when SEG_INVERT=0; 8'hFF when SEG_INVERT=1.
  - In other words, the off level is the pattern 8'h00 after the optional inversion.
- States: IDLE, BLANK, SHOW. A down-counter cnt holds the remaining cycles in the current state; its width covers the larger of DIV_CYCLES and BLANK_CYCLES.
- Reset:
  - State goes to IDLE; digit_idx=0 and cnt=0.
  - The snapshot is cleared to 0.
  - seg_an is at the inactive level, seg_out is at the off level, frame_start=0.
- IDLE:
  - seg_an inactive and seg_out off.
  - When enable is sampled high at edge E, the snapshot captures seg_in_0..7 at E.
  - In the cycle after E: digit_idx=0 and frame_start=1. The state is BLANK with cnt=BLANK_CYCLES, or SHOW with cnt=DIV_CYCLES if BLANK_CYCLES=0.
- BLANK:
  - Lasts exactly BLANK_CYCLES cycles, with seg_an inactive and seg_out off.
  - Then moves to SHOW for the same digit.
- SHOW:
  - Lasts exactly DIV_CYCLES cycles.
  - seg_an is active for digit_idx only; seg_out is the snapshot pattern for digit_idx after optional inversion.
- Leaving SHOW:
  - If digit_idx<7: increment digit_idx and enter BLANK (or SHOW if BLANK_CYCLES=0).
  - If digit_idx=7: wrap digit_idx to 0, take a new snapshot from the live inputs, pulse frame_start for 1 cycle, and enter BLANK/SHOW as at frame start.
- Frame length is exactly 8*(DIV_CYCLES+BLANK_CYCLES) cycles. frame_start period equals the frame length.
- The snapshot is taken only at frame start. Input changes at any other time have no effect until the next frame.
- enable deasserted (sampled low) in any non-IDLE state:
  - Next cycle the state is IDLE, with seg_an inactive and seg_out off.
  - digit_idx=0; any partial frame is abandoned.
  - Re-enabling starts a fresh frame with a new snapshot.
- Reset mid-frame overrides everything and gives the reset values on the next cycle.
- reset and enable both high in the same cycle: reset wins.
- At most one seg_an bit is ever active in any cycle. No cycle has two digits enabled, including the BLANK_CYCLES=0 digit transitions.

Decomposition:
- Shared package gpio_seg_pkg holds:
  - the state enum {IDLE, BLANK, SHOW};
  - the NUM_DIGITS=8 and SEG_W=8 constants;
  - a function that returns the inactive enable vector for a given AN_ACTIVE_LOW.
- No sub-module. The timer, FSM and snapshot registers stay in one module.

Test Plan (DIV_CYCLES=4, BLANK_CYCLES=2, AN_ACTIVE_LOW=1, SEG_INVERT=0 unless stated):
- Reset with enable=0 -> seg_an=8'hFF, seg_out=8'h00, frame_start=0, digit_idx=0, held for 20 cycles.
- seg_in_d=8'h10+d, enable rises -> frame_start high 1 cycle; then per digit 2 cycles seg_an=FF, seg_out=00, followed by 4 cycles seg_an=~(1<<d), seg_out=8'h10+d, for d=0..7; next frame_start exactly 48 cycles after the first.
- Change seg_in_5 to 8'hAA while digit 2 is showing -> digit 5 still shows 8'h15 this frame; shows 8'hAA in the next frame.
- Drop enable during SHOW of digit 3 -> next cycle seg_an=FF, seg_out=00, digit_idx=0; re-enable -> frame_start pulse, scan restarts at digit 0.
- BLANK_CYCLES=0, SEG_INVERT=1 -> no all-off cycles between digits; seg_out=~pattern; exactly one seg_an bit low every cycle; frame length 32 cycles.
- Assert reset for 1 cycle mid-frame with enable held high -> one cycle of reset values, then a new frame with frame_start=1 and digit 0.
